control_sequencer: RTL and testbench

//  Parametrised micro-op sequencer for the SAP-style CPU: turns the IR opcode into a per-T-state control word.

---
 rtl/sap_ctrl_pkg.sv | 55 +++++
 rtl/control_microcode_rom.sv | 79 +++++++
 rtl/control_sequencer.sv | 89 ++++++++
 tb/tb_control_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the SAP control path: opcodes, control-word bit map,
// the idle (nothing asserted) word and the sequencer stage codes.
package sap_ctrl_pkg;

  localparam int SAP_CTRL_W = 15;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_STA = 3'd4;
  localparam logic [2:0] OP_OUT = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  // _N bits are active-low; everything else is active-high.
  localparam int SIG_PC_INC          = 14;
  localparam int SIG_PC_EN           = 13;
  localparam int SIG_PC_LOAD         = 12;
  localparam int SIG_MAR_ADDR_LOAD_N = 11;
  localparam int SIG_MAR_MEM_LOAD_N  = 10;
  localparam int SIG_RAM_EN_N        = 9;
  localparam int SIG_RAM_LOAD_N      = 8;
  localparam int SIG_IR_LOAD_N       = 7;
  localparam int SIG_IR_EN_N         = 6;
  localparam int SIG_A_LOAD_N        = 5;
  localparam int SIG_A_EN            = 4;
  localparam int SIG_B_EN            = 3;
  localparam int SIG_ADDER_SUB       = 2;
  localparam int SIG_B_LOAD_N        = 1;
  localparam int SIG_OUT_LOAD_N      = 0;

  localparam logic [SAP_CTRL_W-1:0] CTRL_IDLE = 15'h0FE3;

  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_IDLE = 3'd6,
    ST_HALT = 3'd7
  } stage_t;

  function automatic logic [SAP_CTRL_W-1:0] sig(input int idx);
    return SAP_CTRL_W'(1) << idx;
  endfunction

  // Asserting a signal always means flipping it away from its idle level.
  function automatic logic [SAP_CTRL_W-1:0] assert_sigs(input logic [SAP_CTRL_W-1:0] sigs);
    return CTRL_IDLE ^ sigs;
  endfunction

endpackage

// File: rtl/control_microcode_rom.sv
// Combinational microcode: (stage, opcode) -> control word, last-T-state flag
// and HLT detect. Opcodes 8 and above decode as NOP.
module control_microcode_rom
  import sap_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  stage_t                  stage,
  input  logic [OPCODE_W-1:0]     opcode,
  output logic [SAP_CTRL_W-1:0]   ctrl_word,
  output logic                    last,
  output logic                    is_hlt
);

  logic [2:0] op;

  always_comb begin
    op        = ((opcode >> 3) == '0) ? opcode[2:0] : OP_NOP;
    ctrl_word = CTRL_IDLE;
    last      = 1'b0;
    is_hlt    = 1'b0;
    case (stage)
      ST_T0: ctrl_word = assert_sigs(sig(SIG_PC_EN) | sig(SIG_MAR_ADDR_LOAD_N));
      ST_T1: ctrl_word = assert_sigs(sig(SIG_PC_INC));
      ST_T2: begin
        ctrl_word = assert_sigs(sig(SIG_RAM_EN_N) | sig(SIG_IR_LOAD_N));
        last      = (op == OP_NOP);
      end
      ST_T3: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
            ctrl_word = assert_sigs(sig(SIG_IR_EN_N) | sig(SIG_MAR_ADDR_LOAD_N));
          OP_OUT: begin
            ctrl_word = assert_sigs(sig(SIG_A_EN) | sig(SIG_OUT_LOAD_N));
            last      = 1'b1;
          end
          OP_JMP: begin
            ctrl_word = assert_sigs(sig(SIG_IR_EN_N) | sig(SIG_PC_LOAD));
            last      = 1'b1;
          end
          OP_HLT: is_hlt = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        case (op)
          OP_LDA: begin
            ctrl_word = assert_sigs(sig(SIG_RAM_EN_N) | sig(SIG_A_LOAD_N));
            last      = 1'b1;
          end
          OP_ADD, OP_SUB:
            ctrl_word = assert_sigs(sig(SIG_RAM_EN_N) | sig(SIG_B_LOAD_N));
          OP_STA:
            ctrl_word = assert_sigs(sig(SIG_A_EN) | sig(SIG_MAR_MEM_LOAD_N));
          default: ;
        endcase
      end
      ST_T5: begin
        case (op)
          OP_ADD: begin
            ctrl_word = assert_sigs(sig(SIG_B_EN) | sig(SIG_A_LOAD_N));
            last      = 1'b1;
          end
          OP_SUB: begin
            ctrl_word = assert_sigs(sig(SIG_B_EN) | sig(SIG_A_LOAD_N) | sig(SIG_ADDER_SUB));
            last      = 1'b1;
          end
          OP_STA: begin
            ctrl_word = assert_sigs(sig(SIG_RAM_LOAD_N));
            last      = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// SAP micro-op sequencer: stage FSM on posedge, control word registered on
// negedge, sticky HALT, run/single-step gating and a retired-instruction count.
module control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int CTRL_W     = SAP_CTRL_W,
  parameter int MAX_STAGES = 6,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                run,
  input  logic                step,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [2:0]          stage,
  output logic                halted,
  output logic                instr_done,
  output logic [CNT_W-1:0]    instr_count
);

  localparam stage_t LAST_T = stage_t'(3'(MAX_STAGES - 1));

  stage_t                  stage_q;
  stage_t                  stage_d;
  logic                    go_r;
  logic                    in_exec;
  logic                    adv_last;
  logic [SAP_CTRL_W-1:0]   rom_word;
  logic                    rom_last;
  logic                    rom_hlt;

  control_microcode_rom #(.OPCODE_W(OPCODE_W)) u_rom (
    .stage     (stage_q),
    .opcode    (opcode),
    .ctrl_word (rom_word),
    .last      (rom_last),
    .is_hlt    (rom_hlt)
  );

  assign in_exec = (stage_q <= LAST_T);

  // go_r is run|step delayed one cycle: a step pulse advances exactly one
  // T-state, and the control word is only driven during that advancing cycle.
  always_comb begin
    stage_d  = stage_q;
    adv_last = 1'b0;
    if (stage_q == ST_HALT) begin
      stage_d = ST_HALT;
    end else if (!in_exec && stage_q != ST_IDLE) begin
      stage_d = ST_IDLE;
    end else if (go_r) begin
      if (stage_q == ST_IDLE) begin
        stage_d = ST_T0;
      end else if (rom_hlt) begin
        stage_d = ST_HALT;
      end else if (rom_last) begin
        stage_d  = ST_T0;
        adv_last = 1'b1;
      end else begin
        stage_d = stage_t'(stage_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stage_q     <= ST_IDLE;
      go_r        <= 1'b0;
      instr_done  <= 1'b0;
      instr_count <= '0;
    end else begin
      stage_q    <= stage_d;
      go_r       <= run | step;
      instr_done <= adv_last;
      if (adv_last) instr_count <= instr_count + 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (!resetn) ctrl <= CTRL_W'(CTRL_IDLE);
    else         ctrl <= CTRL_W'((go_r && in_exec) ? rom_word : CTRL_IDLE);
  end

  assign stage  = stage_q;
  assign halted = (stage_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction micro-program table model,
// directed scenarios plus randomized run/step/opcode stimulus.
module tb_control_sequencer;
  import sap_ctrl_pkg::*;

  localparam logic [3:0] HLT = 4'(OP_HLT);
  localparam logic [3:0] LDA = 4'(OP_LDA);
  localparam logic [3:0] ADD = 4'(OP_ADD);
  localparam logic [3:0] SUB = 4'(OP_SUB);
  localparam logic [3:0] STA = 4'(OP_STA);
  localparam logic [3:0] OUT = 4'(OP_OUT);
  localparam logic [3:0] JMP = 4'(OP_JMP);
  localparam logic [3:0] NOP = 4'(OP_NOP);

  // clock / reset
  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        run    = 1'b0;
  logic        step   = 1'b0;
  logic [3:0]  opcode = 4'd0;
  always #5 clk = ~clk;

  logic [14:0] ctrl, ctrl2;
  logic [2:0]  stage, stage2;
  logic        halted, halted2, done, done2;
  logic [15:0] count;
  logic [1:0]  count2;

  control_sequencer dut (
    .clk(clk), .resetn(resetn), .opcode(opcode), .run(run), .step(step),
    .ctrl(ctrl), .stage(stage), .halted(halted), .instr_done(done), .instr_count(count)
  );

  control_sequencer #(.CNT_W(2)) dut_w2 (
    .clk(clk), .resetn(resetn), .opcode(opcode), .run(run), .step(step),
    .ctrl(ctrl2), .stage(stage2), .halted(halted2), .instr_done(done2), .instr_count(count2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: each opcode is a list of T-state words; kind 0=idle 1=exec 2=halt
  int          m_kind  = 0;
  int          m_t     = 0;
  bit          m_go    = 1'b0;
  bit          m_done  = 1'b0;
  int          m_count = 0;
  logic [14:0] exp_q[$];

  function automatic int prog_len(input logic [3:0] op);
    case (op)
      LDA:           return 5;
      ADD, SUB, STA: return 6;
      OUT, JMP, HLT: return 4;
      default:       return 3;
    endcase
  endfunction

  function automatic logic [14:0] prog_word(input logic [3:0] op, input int t);
    case (t)
      0: return 15'h27E3;
      1: return 15'h4FE3;
      2: return 15'h0D63;
      3: case (op)
           LDA, ADD, SUB, STA: return 15'h07A3;
           OUT:                return 15'h0FF2;
           JMP:                return 15'h1FA3;
           default:            return 15'h0FE3;
         endcase
      4: case (op)
           LDA:      return 15'h0DC3;
           ADD, SUB: return 15'h0DE1;
           STA:      return 15'h0BF3;
           default:  return 15'h0FE3;
         endcase
      5: case (op)
           ADD:     return 15'h0FCB;
           SUB:     return 15'h0FCF;
           STA:     return 15'h0EE3;
           default: return 15'h0FE3;
         endcase
      default: return 15'h0FE3;
    endcase
  endfunction

  task automatic model_negedge();
    if (resetn && m_go && m_kind == 1) exp_q.push_back(prog_word(opcode, m_t));
    else                               exp_q.push_back(15'h0FE3);
  endtask

  task automatic model_posedge();
    if (!resetn) begin
      m_kind = 0; m_t = 0; m_go = 0; m_done = 0; m_count = 0;
    end else begin
      m_done = 0;
      if (m_kind == 1 && m_go) begin
        if (opcode == HLT && m_t == 3) m_kind = 2;
        else if (m_t == prog_len(opcode) - 1) begin
          m_t = 0; m_done = 1; m_count++;
        end else m_t++;
      end else if (m_kind == 0 && m_go) begin
        m_kind = 1; m_t = 0;
      end
      m_go = run | step;
    end
  endtask

  function automatic logic [2:0] m_stage();
    if (m_kind == 0) return 3'd6;
    if (m_kind == 2) return 3'd7;
    return 3'(m_t);
  endfunction

  // driver: one full clock with checks after both edges
  task automatic cycle(input bit r, input bit ru, input bit st, input logic [3:0] op);
    logic [14:0] e;
    logic [15:0] c;
    resetn = r; run = ru; step = st; opcode = op;
    @(negedge clk);
    model_negedge();
    #1;
    e = exp_q.pop_front();
    check("ctrl", ctrl, e);
    check("ctrl_w2", ctrl2, e);
    @(posedge clk);
    model_posedge();
    #1;
    c = 16'(m_count);
    check("stage", stage, m_stage());
    check("halted", halted, m_kind == 2);
    check("instr_done", done, m_done);
    check("instr_count", count, c);
    check("stage_w2", stage2, m_stage());
    check("halted_w2", halted2, m_kind == 2);
    check("instr_done_w2", done2, m_done);
    check("instr_count_w2", count2, c[1:0]);
  endtask

  task automatic run_instr(input logic [3:0] op);
    for (int i = 0; i < prog_len(op); i++) cycle(1, 1, 0, op);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [14:0] lda_ctrl  [7] = '{15'h0FE3, 15'h0FE3, 15'h27E3, 15'h4FE3, 15'h0D63, 15'h07A3, 15'h0DC3};
  logic [2:0]  lda_stage [7] = '{3'd6, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

  initial begin
    @(posedge clk); #1;
    // reset held 3 cycles with run=1
    repeat (3) cycle(0, 1, 0, LDA);
    check("rst_stage", stage, 3'd6);
    check("rst_ctrl", ctrl, 15'h0FE3);
    check("rst_count", count, 16'd0);
    check("rst_done", done, 1'b0);
    check("rst_halted", halted, 1'b0);

    // LDA from reset, fetch then execute
    for (int i = 0; i < 7; i++) begin
      cycle(1, 1, 0, LDA);
      check($sformatf("lda_ctrl_%0d", i), ctrl, lda_ctrl[i]);
      check($sformatf("lda_stage_%0d", i), stage, lda_stage[i]);
      check($sformatf("lda_done_%0d", i), done, i == 6);
    end
    check("lda_count", count, 16'd1);

    run_instr(OUT);
    check("out_t3_ctrl", ctrl, 15'h0FF2);
    check("out_count", count, 16'd2);
    run_instr(JMP);
    check("jmp_t3_ctrl", ctrl, 15'h1FA3);
    check("jmp_count", count, 16'd3);
    run_instr(SUB);
    check("sub_t5_ctrl", ctrl, 15'h0FCF);
    check("sub_adder_sub", ctrl[SIG_ADDER_SUB], 1'b1);
    run_instr(ADD);
    check("add_adder_sub", ctrl[SIG_ADDER_SUB], 1'b0);
    run_instr(STA);
    check("sta_t5_ctrl", ctrl, 15'h0EE3);
    run_instr(4'd12);
    check("undef_count", count, 16'd7);

    // randomized run/step/opcode; opcode only changes at instruction boundaries
    begin
      logic [3:0] op = NOP;
      for (int i = 0; i < 400; i++) begin
        if (m_kind == 0 || m_t == 0) op = 4'($urandom_range(1, 15));
        cycle(1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), op);
      end
    end

    // HLT: sticky, ignores run/step, cleared by reset
    cycle(0, 1, 0, HLT);
    repeat (6) cycle(1, 1, 0, HLT);
    check("hlt_halted", halted, 1'b1);
    check("hlt_stage", stage, 3'd7);
    check("hlt_ctrl", ctrl, 15'h0FE3);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      check("hlt_hold_stage", stage, 3'd7);
      check("hlt_hold_ctrl", ctrl, 15'h0FE3);
    end
    check("hlt_count", count, 16'd0);
    cycle(0, 1, 0, HLT);
    check("hlt_rst_stage", stage, 3'd6);
    check("hlt_rst_halted", halted, 1'b0);

    // single-step: run=0, step every 5th cycle
    for (int i = 0; i < 35; i++) begin
      cycle(1, 0, i % 5 == 4, LDA);
      if (i % 5 != 0) check("step_gap_ctrl", ctrl, 15'h0FE3);
    end
    check("step_stage", stage, 3'd0);
    check("step_count", count, 16'd1);

    // reset in the middle of ADD at T4
    cycle(0, 1, 0, NOP);
    repeat (5) cycle(1, 1, 0, NOP);
    check("pre_add_count", count, 16'd1);
    begin
      int k = 0;
      while (stage !== 3'd4 && k < 20) begin
        cycle(1, 1, 0, ADD);
        k++;
      end
    end
    check("add_t4_reach", stage, 3'd4);
    cycle(0, 1, 0, ADD);
    check("midrst_stage", stage, 3'd6);
    check("midrst_count", count, 16'd0);
    check("midrst_done", done, 1'b0);
    cycle(0, 1, 0, ADD);
    check("midrst_done2", done, 1'b0);

    // counter wrap on the 2-bit instance
    cycle(0, 1, 0, NOP);
    repeat (2) cycle(1, 1, 0, NOP);
    run_instr(NOP);
    run_instr(4'd9);
    run_instr(NOP);
    run_instr(4'd15);
    run_instr(NOP);
    check("wrap_count16", count, 16'd5);
    check("wrap_count2", count2, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
